led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised multi-mode LED driver that generalises the single-pattern mode-1 driver into one engine. It runs N_LED outputs in one of four runtime-selectable patterns: off, chase, bounce, and PWM breathe. Step rate is set by a clock prescaler, and mode changes are handshaked and applied only on step boundaries. It sits between the board-level mode select logic and the LED pins, on the 12 MHz system clock.

## Interface
- N_LED, 8, number of LED outputs (≥1)
- TICK_DIV, 12000, clocks per tick (≥1); 1 ms at 12 MHz
- STEP_TICKS, 100, ticks per pattern step (≥1)
- PWM_BITS, 4, PWM counter/duty width (1..8); PWM period 2^PWM_BITS clocks
- clk  in  1  system clock, 12 MHz nominal
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes the engine and blanks LEDs
- mode  in  2  requested mode: 0 OFF, 1 CHASE, 2 BOUNCE, 3 BREATHE
- mode_load  in  1  one-cycle strobe; captures `mode` into the pending slot
- led_out  out  N_LED  registered LED drive, 1 = on
- step_pulse  out  1  one-cycle pulse per applied step
- mode_ack  out  1  one-cycle pulse when a pending mode takes effect

## Operation
- **Prescaler:** tcnt counts 0..TICK_DIV-1 and wraps. `tick` = (tcnt == TICK_DIV-1) && en.
- **Step counter:** scnt counts ticks 0..STEP_TICKS-1 and wraps. Internal `strobe` = tick && (scnt == STEP_TICKS-1).
- **PWM counter:** pcnt is PWM_BITS wide, free-running while en=1, and wraps naturally.
- **Pending mode:** mode_load sets pend_valid and pend_mode. A later mode_load before application overwrites it (latest wins). mode_load is honoured even while en=0.
- **On strobe with pend_valid:**
  - cur_mode <= pend_mode; pend_valid <= 0.
  - Pattern state resets to initial: pos=0, dir=up, level=0. It does not advance on this strobe.
- **On strobe without pend_valid:** pattern state advances per cur_mode.
- **OFF:** state held; led_out = 0.
- **CHASE:** one-hot at pos; pos advances 0→1→…→N_LED-1→0.
- **BOUNCE:** one-hot at pos.
  - Up: pos increments; at N_LED-1, dir flips and the next step goes to N_LED-2.
  - Down: mirror at 0.
  - N_LED=1: pos stays 0.
  - Sequence for N_LED=4: 0,1,2,3,2,1,0,1…
- **BREATHE:** level ramps 0,1,…,2^PWM_BITS-1, then back down to 0, reversing at both ends without repeating the endpoint. Every LED = (pcnt < level). Level 0 is fully off; max level is on for (2^PWM_BITS-1)/2^PWM_BITS of the period.
- **en=0:**
  - tcnt, scnt, pcnt and pattern state are held.
  - led_out is forced to 0 (registered, so it goes low one cycle after en falls).
  - No strobe occurs, so no mode is applied.
  - On en=1, everything resumes from the held counts.
- **Simultaneous mode_load and strobe in the same cycle:** the strobe applies the previously pending value, if any. The new value is captured as pending and applied at the next strobe. There is no bypass.
- **Reset:**
  - Takes effect immediately (asynchronous) and may arrive mid-step.
  - Clears to: tcnt=0, scnt=0, pcnt=0, cur_mode=OFF, pend_valid=0, pos=0, dir=up, level=0.
  - Outputs: led_out=0, step_pulse=0, mode_ack=0.

## Timing
- Steps occur every TICK_DIV×STEP_TICKS enabled clocks. The first strobe comes at enabled cycle TICK_DIV×STEP_TICKS-1 after reset release.
- Clock edge with strobe: pattern state and cur_mode update.
- step_pulse and mode_ack are registered. Both are high for exactly the one cycle following the strobe edge. mode_ack is asserted only when a mode was applied on that strobe.
- led_out is registered from cur_mode, pattern state and pcnt. A new pattern appears on led_out the cycle after step_pulse.
- mode_load to effect: from 1 up to TICK_DIV×STEP_TICKS cycles, plus the strobe-coincidence case above.
- No combinational path from any input to any output.

## Test plan
Bench parameters: N_LED=4, TICK_DIV=4, STEP_TICKS=2, PWM_BITS=2, giving a step every 8 clocks.

1. **Reset default:** release rst, en=1, no mode_load for 40 clocks → led_out=0000 throughout; step_pulse pulses every 8 clocks; mode_ack never asserts.
2. **Chase:** load mode=1 → mode_ack with the next step_pulse; led_out then shows 0001, 0010, 0100, 1000, 0001 on successive steps.
3. **Bounce:** load mode=2 → led_out 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. **Breathe:** load mode=3 → level sequence 0,1,2,3,2,1,0. At level 1, each LED is on 1 of every 4 clocks; at level 3, on 3 of 4; at level 0, always 0.
5. **Handshake corners:**
   - Two mode_loads (1 then 2) within one step → only mode 2 applied, one mode_ack.
   - mode_load asserted in the exact strobe cycle → applied one step later.
   - en low for 20 clocks → led_out=0, no step_pulse; on resume, the pattern continues from the held position.
6. **Reset mid-operation:** assert rst during CHASE at pos=2, mid-step → led_out=0 immediately after reset; after release, mode is OFF until a new mode_load.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - mode-control and LED-drive bundle for led_pattern_engine
interface led_pattern_engine_if #(
  parameter int N_LED = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             mode_load;
  logic [N_LED-1:0] led_out;
  logic             step_pulse;
  logic             mode_ack;

  modport master (
    output en, mode, mode_load,
    input  led_out, step_pulse, mode_ack
  );

  modport slave (
    input  en, mode, mode_load,
    output led_out, step_pulse, mode_ack
  );
endinterface

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - multi-mode LED driver (off/chase/bounce/breathe) with step-aligned mode changes
module led_pattern_engine #(
  parameter int N_LED      = 8,
  parameter int TICK_DIV   = 12000,
  parameter int STEP_TICKS = 100,
  parameter int PWM_BITS   = 4
) (
  input logic           clk,
  input logic           rst,
  led_pattern_engine_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int PW = (N_LED > 1) ? $clog2(N_LED) : 1;

  localparam logic [TW-1:0]       TCNT_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]       SCNT_MAX = SW'(STEP_TICKS - 1);
  localparam logic [PW-1:0]       POS_MAX  = PW'(N_LED - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [SW-1:0]       scnt_q, scnt_d;
  logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
  mode_e               cur_mode_q, cur_mode_d;
  mode_e               pend_mode_q, pend_mode_d;
  logic                pend_valid_q, pend_valid_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                step_pulse_q, step_pulse_d;
  logic                mode_ack_q, mode_ack_d;

  logic tick;
  logic strobe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q       <= '0;
      scnt_q       <= '0;
      pcnt_q       <= '0;
      cur_mode_q   <= MODE_OFF;
      pend_mode_q  <= MODE_OFF;
      pend_valid_q <= 1'b0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      level_q      <= '0;
      led_q        <= '0;
      step_pulse_q <= 1'b0;
      mode_ack_q   <= 1'b0;
    end else begin
      tcnt_q       <= tcnt_d;
      scnt_q       <= scnt_d;
      pcnt_q       <= pcnt_d;
      cur_mode_q   <= cur_mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      level_q      <= level_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
      mode_ack_q   <= mode_ack_d;
    end
  end

  // Timebase: prescaler, tick counter and PWM phase all freeze together when en is low.
  always_comb begin
    tick   = bus.en && (tcnt_q == TCNT_MAX);
    strobe = tick && (scnt_q == SCNT_MAX);

    tcnt_d = tcnt_q;
    scnt_d = scnt_q;
    pcnt_d = pcnt_q;
    if (bus.en) begin
      tcnt_d = (tcnt_q == TCNT_MAX) ? '0 : tcnt_q + TW'(1);
      pcnt_d = pcnt_q + PWM_BITS'(1);
    end
    if (tick) begin
      scnt_d = (scnt_q == SCNT_MAX) ? '0 : scnt_q + SW'(1);
    end
  end

  // A load in the strobe cycle lands in the pending slot after the old value is consumed.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    if (strobe && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end
    if (bus.mode_load) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_e'(bus.mode);
    end
  end

  always_comb begin
    cur_mode_d = cur_mode_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    level_d    = level_q;
    if (strobe) begin
      if (pend_valid_q) begin
        cur_mode_d = pend_mode_q;
        pos_d      = '0;
        dir_d      = 1'b0;
        level_d    = '0;
      end else begin
        unique case (cur_mode_q)
          MODE_CHASE: begin
            pos_d = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
          end
          MODE_BOUNCE: begin
            if (N_LED > 1) begin
              if (!dir_q) begin
                if (pos_q == POS_MAX) begin
                  pos_d = pos_q - PW'(1);
                  dir_d = 1'b1;
                end else begin
                  pos_d = pos_q + PW'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d = pos_q + PW'(1);
                  dir_d = 1'b0;
                end else begin
                  pos_d = pos_q - PW'(1);
                end
              end
            end
          end
          MODE_BREATHE: begin
            // dir_q doubles as the ramp direction; it is cleared on every mode change.
            if (!dir_q) begin
              if (level_q == LVL_MAX) begin
                level_d = level_q - PWM_BITS'(1);
                dir_d   = 1'b1;
              end else begin
                level_d = level_q + PWM_BITS'(1);
              end
            end else begin
              if (level_q == '0) begin
                level_d = level_q + PWM_BITS'(1);
                dir_d   = 1'b0;
              end else begin
                level_d = level_q - PWM_BITS'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    led_d        = '0;
    step_pulse_d = strobe;
    mode_ack_d   = strobe && pend_valid_q;
    if (bus.en) begin
      unique case (cur_mode_q)
        MODE_CHASE, MODE_BOUNCE: led_d = N_LED'(1) << pos_q;
        MODE_BREATHE:            led_d = (pcnt_q < level_q) ? '1 : '0;
        default:                 led_d = '0;
      endcase
    end
  end

  assign bus.led_out    = led_q;
  assign bus.step_pulse = step_pulse_q;
  assign bus.mode_ack   = mode_ack_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed and random checks of led_pattern_engine against a step-index model
module tb_led_pattern_engine;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 2;
  localparam int PB = 2;
  localparam int SP = TD * ST;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_pattern_engine_if #(.N_LED(N)) ifc ();

  led_pattern_engine #(
    .N_LED(N), .TICK_DIV(TD), .STEP_TICKS(ST), .PWM_BITS(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int errors = 0;

  // Model: enabled-cycle count since reset, current/pending mode, steps since the mode was applied.
  int         ecnt;
  int         m_cur;
  int         m_pend;
  bit         pv;
  int         k;
  logic [N-1:0] e_led;
  logic       e_sp;
  logic       e_ack;

  function automatic int tri_wave(int kk, int mx);
    int r;
    if (mx == 0) return 0;
    r = kk % (2 * mx);
    return (r <= mx) ? r : 2 * mx - r;
  endfunction

  function automatic logic [N-1:0] pattern(int md, int kk, int p);
    logic [N-1:0] one;
    one = 1;
    case (md)
      1:       return one << (kk % N);
      2:       return one << tri_wave(kk, N - 1);
      3:       return (p < tri_wave(kk, (1 << PB) - 1)) ? {N{1'b1}} : {N{1'b0}};
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    ecnt = 0; m_cur = 0; m_pend = 0; pv = 0; k = 0;
    e_led = '0; e_sp = 1'b0; e_ack = 1'b0;
  endtask

  task automatic model_edge();
    bit strobe;
    if (rst) begin
      model_reset();
      return;
    end
    strobe = ifc.en && (ecnt % SP == SP - 1);
    e_led  = ifc.en ? pattern(m_cur, k, ecnt % (1 << PB)) : '0;
    e_sp   = strobe;
    e_ack  = strobe && pv;
    if (strobe) begin
      if (pv) begin
        m_cur = m_pend; pv = 0; k = 0;
      end else begin
        k++;
      end
    end
    if (ifc.mode_load) begin
      pv = 1; m_pend = int'(ifc.mode);
    end
    if (ifc.en) ecnt++;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("led_out", 32'(ifc.led_out), 32'(e_led));
      chk("step_pulse", 32'(ifc.step_pulse), 32'(e_sp));
      chk("mode_ack", 32'(ifc.mode_ack), 32'(e_ack));
    end
  endtask

  task automatic load(int md);
    ifc.mode      = 2'(md);
    ifc.mode_load = 1'b1;
    cyc(1);
    ifc.mode_load = 1'b0;
  endtask

  // Advance until the next edge is the one at enabled-cycle phase p.
  task automatic wait_phase(int p);
    for (int i = 0; i < 4 * SP; i++) begin
      if (ecnt % SP == p) return;
      cyc(1);
    end
    checks++;
    errors++;
    $error("FAIL wait_phase observed=timeout expected=phase_%0d", p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    ifc.en        = 1'b0;
    ifc.mode      = 2'd0;
    ifc.mode_load = 1'b0;
    model_reset();
    cyc(3);
    rst    = 1'b0;
    ifc.en = 1'b1;

    // Reset default: OFF, pulses every step, no ack.
    cyc(40);

    // Chase, bounce, breathe.
    load(1);
    cyc(6 * SP);
    load(2);
    cyc(9 * SP);
    load(3);
    cyc(8 * SP);

    // Two loads within one step: latest wins, one ack.
    wait_phase(0);
    load(1);
    cyc(2);
    load(2);
    cyc(2 * SP);

    // Load coincident with the strobe edge: applied one step later.
    wait_phase(SP - 1);
    load(1);
    cyc(3 * SP);

    // Enable low freezes everything and blanks LEDs.
    wait_phase(3);
    ifc.en = 1'b0;
    cyc(20);
    ifc.en = 1'b1;
    cyc(3 * SP);

    // Asynchronous reset during chase at pos 2, mid-step.
    wait_phase(0);
    load(1);
    wait_phase(SP - 1);
    cyc(1);
    cyc(2 * SP);
    cyc(3);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("led_out_async_rst", 32'(ifc.led_out), 32'(e_led));
    chk("step_pulse_async_rst", 32'(ifc.step_pulse), 32'(e_sp));
    cyc(2);
    rst = 1'b0;
    cyc(3 * SP);

    // Random enable gaps and loads.
    for (int i = 0; i < 80; i++) begin
      ifc.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0) load(int'($urandom_range(0, 3)));
      else cyc(int'($urandom_range(1, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
